// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, threshold flags and sticky overflow/underflow errors.
module fifo_sync #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 64,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4,
   parameter bit FWFT      = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   input  logic                       i_clr_err,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_rd_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_almost_full,
   output logic                       o_almost_empty,
   output logic                       o_overflow,
   output logic                       o_underflow
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             wr_acc, rd_acc;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full         = count_q == CW'(DEPTH);
   assign o_empty        = count_q == '0;
   assign o_almost_full  = count_q >= CW'(AFULL_TH);
   assign o_almost_empty = count_q <= CW'(AEMPTY_TH);
   assign o_count        = count_q;
   assign o_overflow     = ovf_q;
   assign o_underflow    = udf_q;
   assign o_rd_data      = FWFT ? mem_q[rd_ptr_q] : rd_data_q;
   assign o_rd_valid     = FWFT ? !o_empty : rd_valid_q;

   // flush swallows any same-cycle transfer but leaves error detection alone
   always_comb begin
      wr_acc     = i_wr_en && !o_full && !i_flush;
      rd_acc     = i_rd_en && !o_empty && !i_flush;
      wr_ptr_d   = i_flush ? '0 : wr_acc ? nxt(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = i_flush ? '0 : rd_acc ? nxt(rd_ptr_q) : rd_ptr_q;
      count_d    = i_flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
      ovf_d      = (i_wr_en && o_full) || (ovf_q && !i_clr_err);
      udf_d      = (i_rd_en && o_empty) || (udf_q && !i_clr_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
   end
endmodule
